// File: rtl/countdown_timer.sv
// BCD mm:ss countdown timer stepped by rising edges of a synchronized 1 Hz square wave.
// Count and flags are registered; a tick lands 3 cycles after sec_clk rises; no backpressure.
module countdown_timer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clkin,
  input  logic       clr_n,
  input  logic       sec_clk,
  input  logic       load,
  input  logic [7:0] preset_min,
  input  logic [7:0] preset_sec,
  input  logic       start,
  input  logic       pause,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       running,
  output logic       expired,
  output logic       done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED, S_DONE} state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   tick;
  logic [7:0]             min_nxt, sec_nxt;
  logic                   expired_nxt;
  logic                   preset_ok;
  logic                   count_nz;

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    else                return {v[7:4], v[3:0] - 4'd1};
  endfunction

  function automatic logic bcd_ok(input logic [7:0] v, input logic [3:0] max_tens);
    return (v[3:0] <= 4'd9) && (v[7:4] <= max_tens);
  endfunction

  always_ff @(posedge clkin) begin
    if (!clr_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sec_clk};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign tick      = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign preset_ok = bcd_ok(preset_min, 4'd9) && bcd_ok(preset_sec, 4'd5);
  assign count_nz  = ({min_bcd, sec_bcd} != 16'h0000);

  // A control action in a cycle consumes that cycle's tick; a rejected preset acts as no load.
  always_comb begin
    state_nxt   = state;
    min_nxt     = min_bcd;
    sec_nxt     = sec_bcd;
    expired_nxt = 1'b0;
    if (load && preset_ok) begin
      state_nxt = S_IDLE;
      min_nxt   = preset_min;
      sec_nxt   = preset_sec;
    end else if (start && !pause && (state == S_IDLE || state == S_PAUSED)) begin
      if (state == S_PAUSED || count_nz) state_nxt = S_RUN;
    end else if (pause && !start && state == S_RUN) begin
      state_nxt = S_PAUSED;
    end else if (tick && state == S_RUN) begin
      if (sec_bcd != 8'h00) begin
        sec_nxt = bcd_dec(sec_bcd);
      end else begin
        sec_nxt = 8'h59;
        min_nxt = bcd_dec(min_bcd);
      end
      if ({min_nxt, sec_nxt} == 16'h0000) begin
        state_nxt   = S_DONE;
        expired_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clkin) begin
    if (!clr_n) begin
      state   <= S_IDLE;
      min_bcd <= 8'h00;
      sec_bcd <= 8'h00;
      running <= 1'b0;
      expired <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      min_bcd <= min_nxt;
      sec_bcd <= sec_nxt;
      running <= (state_nxt == S_RUN);
      expired <= expired_nxt;
      done    <= (state_nxt == S_DONE);
    end
  end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

BCD minutes:seconds countdown timer that consumes the 1 Hz square wave produced by the frequency divider and turns each of its rising edges into a one-second decrement. It sits directly downstream of the divider, on the same fast clock. It supplies the count, run status and expiry flags to the display and game-control logic.

## Interface

Parameters:
- SYNC_STAGES, default 2: flip-flop stages synchronizing sec_clk before edge detection (legal ≥ 2).

Ports:
- clkin, in, 1: system clock (50 MHz); the only clock.
- clr_n, in, 1: reset, synchronous and active-low.
- sec_clk, in, 1: slow square wave from the divider; each rising edge means one second.
- load, in, 1: load preset_min/preset_sec and go IDLE.
- preset_min, in, 8: BCD minutes, 00–99.
- preset_sec, in, 8: BCD seconds, 00–59.
- start, in, 1: begin or resume counting.
- pause, in, 1: suspend counting.
- min_bcd, out, 8: current minutes, BCD.
- sec_bcd, out, 8: current seconds, BCD.
- running, out, 1: high in RUN.
- expired, out, 1: one-cycle pulse on reaching 00:00 by decrement.
- done, out, 1: high in DONE.

## Operation

- Reset (clr_n=0 at a clkin edge):
  - State goes to IDLE.
  - min_bcd=00, sec_bcd=00.
  - running=0, expired=0, done=0.
  - Synchronizer and edge registers cleared.
- Tick generation: sec_clk passes through SYNC_STAGES flops plus one previous-value flop. tick = sync_out & ~prev.
  - Exactly one tick per sec_clk rising edge.
  - Falling edges are ignored.
- States:
  - IDLE → RUN on start when the count ≠ 00:00. start is ignored when the count is 00:00.
  - RUN → PAUSED on pause.
  - RUN → DONE when a tick decrements the count to 00:00.
  - PAUSED → RUN on start.
  - DONE is left only via load or reset. start and pause are ignored in DONE.
- Priority per cycle: clr_n > load > start/pause > tick.
- load:
  - Accepted in any state, only if every digit is valid BCD, preset_min ≤ 99 and preset_sec ≤ 59.
  - On acceptance: count ← preset, state ← IDLE, done ← 0.
  - An invalid preset is ignored entirely; state and count are unchanged.
- start and pause in the same cycle: no state change.
- Decrement (RUN and tick only):
  - sec ≠ 00: sec − 1 in BCD; units 0 → 9 with tens − 1 (e.g. 40 → 39).
  - sec = 00 and min ≠ 00: min − 1 in BCD, sec ← 59.
  - Result 00:00: expired pulses and the state enters DONE.
- Ticks outside RUN are discarded, not queued.
- A tick in the same cycle as pause (RUN) or start (PAUSED/IDLE) is discarded.

## Timing

- All outputs are registered.
- Tick latency: a sec_clk rising edge first sampled at clkin edge N produces tick during cycle N+SYNC_STAGES (N+2 by default).
- Count update, running/done/expired change: on the clkin edge ending the tick cycle, i.e. visible from cycle N+SYNC_STAGES+1.
- Control latency: load, start and pause sampled at edge E take effect in outputs after E (1 cycle).
- expired is high for exactly one cycle, the same cycle min_bcd/sec_bcd first read 00:00 and done rises.
- Reset mid-count: counting stops at the reset edge. The count reads 00:00 the following cycle.
- If sec_clk is high when clr_n releases, one spurious tick may fire 2 cycles later. It is harmless because the block is in IDLE.
- Minimum sec_clk high and low time: SYNC_STAGES+1 clkin cycles.

## Test plan

- Reset:
  - Stimulus: drive clr_n=0 for 2 cycles mid-RUN at 01:30.
  - Required: min=00, sec=00, running=0, done=0, expired=0 in the cycle after the reset edge.
- Countdown:
  - Stimulus: load 00:03, start, then 3 sec_clk periods.
  - Required: sec reads 02, 01, 00, each update 3 cycles after the rising edge. expired is high exactly one cycle with the third update. done=1, running=0.
- BCD borrow:
  - Stimulus: load 10:00, start, one tick.
  - Required: reads 09:59.
  - Stimulus: load 00:40, start, one tick.
  - Required: reads 00:39.
- Pause/resume:
  - Stimulus: load 00:05, start; assert pause in the same cycle as a tick; apply 2 more ticks in PAUSED; then start.
  - Required: count remains 00:05 through PAUSED. The next tick after resume gives 00:04.
- Invalid and zero loads:
  - Stimulus: load 00:60, then 0A:00.
  - Required: both ignored; count and state unchanged.
  - Stimulus: load 00:00, then start.
  - Required: stays IDLE, running=0.
- DONE stickiness:
  - Stimulus: in DONE, apply start and ticks.
  - Required: no change.
  - Stimulus: load 02:00 from DONE.
  - Required: done=0, IDLE, count 02:00.
